seq_det_mealy: RTL

- Parametrised Mealy sequence detector; successor to the fixed two-state Mealy colour FSM.
- Matches a runtime-loadable pattern of PAT_LEN symbols, each SYM_W bits wide, against a valid-qualified symbol stream.
- Overlapping matches are supported. The match output is combinational (Mealy) in the same cycle as the completing symbol.
- Also provides one-shot/continuous mode and a saturating match counter. Sits on the control path between the input decoder and the event/interrupt logic.

---
 rtl/seq_det_pkg.sv | 44 ++++
 rtl/seq_det_border.sv | 43 ++++
 rtl/seq_det_mealy.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the seq_det_mealy sequence detector.
// Symbols are packed LSB-first: symbol 0 occupies the lowest SYM_W bits.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } seq_state_t;

   localparam int PAT_LEN_DEFAULT = 4;
   localparam int PROG_W_DEFAULT  = $clog2(PAT_LEN_DEFAULT);

   // Upper bound on PAT_LEN*SYM_W supported by suffixIsPrefix.
   localparam int MAX_SEQ_BITS = 64;
   localparam int IDX_W        = $clog2(MAX_SEQ_BITS);

   function automatic int progWidth(input int patLen);
      return $clog2(patLen);
   endfunction

   // True when the last k symbols of a seqLen-symbol sequence equal pattern symbols 0..k-1.
   function automatic logic suffixIsPrefix(
      input logic [MAX_SEQ_BITS-1:0] seqBits,
      input logic [MAX_SEQ_BITS-1:0] patBits,
      input int                      seqLen,
      input int                      k,
      input int                      symW
   );
      logic eq;
      int   base;
      eq   = 1'b1;
      base = (seqLen - k) * symW;
      for (int b = 0; b < MAX_SEQ_BITS; b++) begin
         if (b < k * symW) begin
            if (seqBits[IDX_W'(base + b)] != patBits[IDX_W'(b)]) begin
               eq = 1'b0;
            end
         end
      end
      return eq;
   endfunction

endpackage

// File: rtl/seq_det_border.sv
// Combinational match/next-progress logic for seq_det_mealy: finds the longest
// proper pattern prefix that ends the current history plus incoming symbol.
module seq_det_border
   import seq_det_pkg::*;
#(
   parameter int SYM_W   = 2,
   parameter int PAT_LEN = 4,
   parameter int PROG_W  = PROG_W_DEFAULT
) (
   input  logic [PAT_LEN*SYM_W-1:0]     pattern_i,
   input  logic [(PAT_LEN-1)*SYM_W-1:0] history_i,
   input  logic [SYM_W-1:0]             sym_i,
   input  logic [PROG_W-1:0]            progress_i,
   output logic [PROG_W-1:0]            progressNext_o,
   output logic                         match_o
);

   localparam int SEQ_BITS = PAT_LEN * SYM_W;

   logic [MAX_SEQ_BITS-1:0] seqBits;
   logic [MAX_SEQ_BITS-1:0] patBits;
   logic [SYM_W-1:0]        lastPatSym;

   assign lastPatSym = pattern_i[SEQ_BITS-1 -: SYM_W];
   assign match_o    = (progress_i == PROG_W'(PAT_LEN - 1)) && (sym_i == lastPatSym);

   // Candidate k is capped at progress+1 so zero-filled history after a load or
   // clear can never pose as real matched symbols.
   always_comb begin
      seqBits                = '0;
      patBits                = '0;
      progressNext_o         = '0;
      seqBits[SEQ_BITS-1:0]  = {sym_i, history_i};
      patBits[SEQ_BITS-1:0]  = pattern_i;
      for (int k = 1; k < PAT_LEN; k++) begin
         if ((k <= int'(progress_i) + 1) &&
             suffixIsPrefix(seqBits, patBits, PAT_LEN, k, SYM_W)) begin
            progressNext_o = PROG_W'(k);
         end
      end
   end

endmodule

// File: rtl/seq_det_mealy.sv
// Parametrised Mealy sequence detector with overlap, one-shot mode and a
// saturating match counter. Optional idle-gap timeout: SEQ_DET_GAP_TIMEOUT_EN.
module seq_det_mealy
   import seq_det_pkg::*;
#(
   parameter int SYM_W       = 2,
   parameter int PAT_LEN     = 4,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pat_load,
   input  logic [PAT_LEN*SYM_W-1:0]   pat_data,
   input  logic                       one_shot,
   input  logic                       clear,
   input  logic                       in_valid,
   input  logic [SYM_W-1:0]           in_sym,
   output logic                       match,
   output logic [$clog2(PAT_LEN)-1:0] progress,
   output logic [CNT_W-1:0]           match_count,
   output logic [1:0]                 state
);

   localparam int PW = progWidth(PAT_LEN);
   localparam int HW = (PAT_LEN - 1) * SYM_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef logic [$clog2(TIMEOUT_CYC + 1)-1:0] gap_cnt_t;

   seq_state_t                 state_q, state_d;
   logic [PAT_LEN*SYM_W-1:0]   pat_q, pat_d;
   logic                       oneShot_q, oneShot_d;
   logic [HW-1:0]              hist_q, hist_d;
   logic [PW-1:0]              prog_q, prog_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [PW-1:0]              borderProg;
   logic                       borderMatch;
   logic                       accept;
   logic                       gapExpire;
   logic [PAT_LEN*SYM_W-1:0]   seqCat;

   seq_det_border #(
      .SYM_W   (SYM_W),
      .PAT_LEN (PAT_LEN),
      .PROG_W  (PW)
   ) uBorder (
      .pattern_i      (pat_q),
      .history_i      (hist_q),
      .sym_i          (in_sym),
      .progress_i     (prog_q),
      .progressNext_o (borderProg),
      .match_o        (borderMatch)
   );

   assign accept      = (state_q == ARMED) && in_valid && !pat_load && !clear;
   assign match       = accept && borderMatch;
   assign seqCat      = {in_sym, hist_q};
   assign progress    = prog_q;
   assign match_count = cnt_q;
   assign state       = state_q;

`ifdef SEQ_DET_GAP_TIMEOUT_EN
   gap_cnt_t gap_q, gap_d;

   // Counts idle cycles while a partial match is pending; expiry drops the prefix.
   always_comb begin
      gap_d     = gap_q;
      gapExpire = 1'b0;
      if (pat_load || clear || accept) begin
         gap_d = '0;
      end else if ((state_q == ARMED) && (prog_q != '0)) begin
         if (gap_q == gap_cnt_t'(TIMEOUT_CYC - 1)) begin
            gap_d     = '0;
            gapExpire = 1'b1;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end
`else
   assign gapExpire = 1'b0;
`endif

   // Next-state logic; pat_load beats clear, which beats a stream symbol.
   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      oneShot_d = oneShot_q;
      hist_d    = hist_q;
      prog_d    = prog_q;
      cnt_d     = cnt_q;
      if (pat_load) begin
         state_d   = ARMED;
         pat_d     = pat_data;
         oneShot_d = one_shot;
         hist_d    = '0;
         prog_d    = '0;
         cnt_d     = '0;
      end else if (clear) begin
         if (state_q != IDLE) begin
            state_d = ARMED;
         end
         hist_d = '0;
         prog_d = '0;
         cnt_d  = '0;
      end else begin
         case (state_q)
            ARMED: begin
               if (accept) begin
                  hist_d = seqCat[PAT_LEN*SYM_W-1:SYM_W];
                  prog_d = borderProg;
                  if (borderMatch) begin
                     if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                     end
                     if (oneShot_q) begin
                        state_d = DONE;
                     end
                  end
               end else if (gapExpire) begin
                  hist_d = '0;
                  prog_d = '0;
               end
            end
            IDLE, DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         oneShot_q <= 1'b0;
         hist_q    <= '0;
         prog_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         oneShot_q <= oneShot_d;
         hist_q    <= hist_d;
         prog_q    <= prog_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule
